// File: rtl/ps2_rx_ctrl.sv
// Host-side PS/2 receiver: synchronizes the PS/2 lines, assembles and checks 11-bit frames,
// folds E0/F0 prefixes into flags and queues key events in a first-word-fall-through FIFO.
module ps2_rx_ctrl #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_code,
    output logic       out_break,
    output logic       out_ext,
    output logic       frame_err,
    output logic       overflow,
    input  logic       clr_err
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYC - 1);
    localparam logic [CntW-1:0] FullCnt  = CntW'(FIFO_DEPTH);
    localparam logic [7:0]      ExtCode  = 8'hE0;
    localparam logic [7:0]      BrkCode  = 8'hF0;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCheck
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers; lines idle high, so reset to 1 to avoid a false edge.
    // ------------------------------------------------------------------
    logic [2:0] clk_sync_q;
    logic [2:0] data_sync_q;
    logic       fall;
    logic       sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q <= {data_sync_q[1:0], ps2_data};
        end
    end

    assign fall   = (clk_sync_q[2:1] == 2'b10);
    assign sample = data_sync_q[2];

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [10:0]     shift_q, shift_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            ext_pend_q, ext_pend_d;
    logic            brk_pend_q, brk_pend_d;

    logic            frame_ok;
    logic [7:0]      frame_byte;
    logic            push_req;
    logic [9:0]      push_entry;

    assign frame_byte = shift_q[8:1];
    assign frame_ok   = ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);
    assign push_entry = {ext_pend_q, brk_pend_q, frame_byte};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            tmo_q      <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            tmo_q      <= tmo_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        tmo_d      = tmo_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        push_req   = 1'b0;
        frame_err  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (fall) begin
                    shift_d   = {sample, shift_q[10:1]};
                    bit_cnt_d = 4'd1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (fall) begin
                    shift_d   = {sample, shift_q[10:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tmo_d     = '0;
                    if (bit_cnt_q == 4'd10) begin
                        state_d = StCheck;
                    end
                end else if (tmo_q == TmoLast) begin
                    // Keyboard stalled mid-frame: drop it silently.
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    tmo_d     = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StCheck: begin
                state_d   = StIdle;
                bit_cnt_d = '0;
                tmo_d     = '0;
                if (!frame_ok) begin
                    frame_err  = 1'b1;
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end else if (frame_byte == ExtCode) begin
                    ext_pend_d = 1'b1;
                end else if (frame_byte == BrkCode) begin
                    brk_pend_d = 1'b1;
                end else begin
                    push_req   = 1'b1;
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
            end
            default: begin
                state_d   = StIdle;
                bit_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Event FIFO, entry = {ext, break, code}
    // ------------------------------------------------------------------
    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            overflow_q;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    assign full      = (count_q == FullCnt);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still takes the event when the head leaves in the same cycle.
    assign push      = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            overflow_q <= drop | (overflow_q & ~clr_err);
        end
    end

    assign overflow  = overflow_q;
    assign out_ext   = mem_q[rd_ptr_q][9];
    assign out_break = mem_q[rd_ptr_q][8];
    assign out_code  = mem_q[rd_ptr_q][7:0];

endmodule
